// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-segment seven-segment display.
// Holds a hex value and an enable bit per digit and cycles through the digits.
// Each digit gets a dark GAP slot followed by a lit DWELL slot.
// The current digit's value is presented on x1..x4 for the shared decoder.
// The matching one-hot digit select is driven while that digit is lit.
module seg_scan_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DWELL  = 1000,
    parameter int unsigned GAP    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              wr_on,
    output logic              x1,
    output logic              x2,
    output logic              x3,
    output logic              x4,
    output logic [DIGITS-1:0] digit_sel,
    output logic              frame_tick
);

    localparam int unsigned CntMax = (DWELL > GAP) ? DWELL : GAP;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned IdxW   = $clog2(DIGITS);

    localparam logic [CntW-1:0] GapLast   = CntW'(GAP - 1);
    localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(DIGITS - 1);

    typedef enum logic [0:0] {
        StGap,
        StShow
    } state_e;

    // Digit register file
    logic [3:0]        value_q [DIGITS];
    logic [3:0]        value_d [DIGITS];
    logic [DIGITS-1:0] on_q;
    logic [DIGITS-1:0] on_d;
    logic              wr_hit;
    logic [IdxW-1:0]   wr_idx;

    // Scan sequencer
    state_e            state_q;
    state_e            state_d;
    logic [CntW-1:0]   cnt_q;
    logic [CntW-1:0]   cnt_d;
    logic [IdxW-1:0]   idx_q;
    logic [IdxW-1:0]   idx_d;
    logic              tick_q;
    logic              tick_d;
    logic [DIGITS-1:0] sel_q;
    logic [DIGITS-1:0] sel_d;

    // Out-of-range addresses are dropped rather than aliased onto a real digit.
    assign wr_hit = wr_en && ({1'b0, wr_addr} < 4'(DIGITS));
    assign wr_idx = wr_addr[IdxW-1:0];

    // Next contents of the register file after this edge's write, if any.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            value_d[i] = value_q[i];
            on_d[i]    = on_q[i];
        end
        if (wr_hit) begin
            value_d[wr_idx] = wr_data;
            on_d[wr_idx]    = wr_on;
        end
    end

    // Register file storage; every digit comes out of reset enabled and showing 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                value_q[i] <= 4'h0;
            end
            on_q <= '1;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                value_q[i] <= value_d[i];
            end
            on_q <= on_d;
        end
    end

    // Sequencer next state: GAP/SHOW slots per digit, advance the digit after each SHOW.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        tick_d  = 1'b0;
        if (!scan_en) begin
            // Park dark at the start of a gap; the digit index is kept so the
            // scan resumes where it stopped.
            state_d = StGap;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StGap: begin
                    if (cnt_q == GapLast) begin
                        state_d = StShow;
                        cnt_d   = '0;
                    end
                end
                StShow: begin
                    if (cnt_q == DwellLast) begin
                        state_d = StGap;
                        cnt_d   = '0;
                        if (idx_q == IdxLast) begin
                            idx_d  = '0;
                            tick_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Next digit select, built from next-state values so the registered drive
    // lines up with the state register. A blanked digit keeps its slot but stays dark.
    always_comb begin
        sel_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            sel_d[i] = (state_d == StShow) && on_d[i] && (idx_d == IdxW'(i));
        end
    end

    // Sequencer state, frame tick and digit select registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StGap;
            cnt_q   <= '0;
            idx_q   <= '0;
            tick_q  <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            sel_q   <= sel_d;
        end
    end

    // Outputs come straight from registers; no input reaches them combinationally.
    always_comb begin
        {x1, x2, x3, x4} = value_q[idx_q];
        digit_sel        = sel_q;
        frame_tick       = tick_q;
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed steps followed by a
// randomized run, all checked against a slot-position reference model.
module tb_seg_scan_ctrl;

    localparam int D     = 4;
    localparam int G     = 2;
    localparam int W     = 4;
    localparam int FRAME = D * (G + W);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         scan_en = 1'b1;
    logic         wr_en = 1'b0;
    logic [2:0]   wr_addr = 3'd0;
    logic [3:0]   wr_data = 4'h0;
    logic         wr_on = 1'b1;
    logic         x1, x2, x3, x4;
    logic [D-1:0] digit_sel;
    logic         frame_tick;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int last_tick = -1;
    int prev_tick = -1;

    // Reference model: digit index and position within its GAP+DWELL slot.
    int         m_t;
    int         m_idx;
    logic [3:0] m_val [D];
    bit         m_on [D];
    bit         m_tick;

    seg_scan_ctrl #(
        .DIGITS (D),
        .DWELL  (W),
        .GAP    (G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_en    (scan_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_on      (wr_on),
        .x1         (x1),
        .x2         (x2),
        .x3         (x3),
        .x4         (x4),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_t = 0;
        m_idx = 0;
        m_tick = 0;
        for (int i = 0; i < D; i++) begin
            m_val[i] = 4'h0;
            m_on[i] = 1'b1;
        end
    endtask

    task automatic model_edge();
        int a;
        if (rst) begin
            model_reset();
        end else begin
            m_tick = 0;
            a = int'(wr_addr);
            if (wr_en && a < D) begin
                m_val[a] = wr_data;
                m_on[a] = wr_on;
            end
            if (!scan_en) begin
                m_t = 0;
            end else begin
                m_t++;
                if (m_t == G + W) begin
                    m_t = 0;
                    if (m_idx == D - 1) m_tick = 1;
                    m_idx = (m_idx + 1) % D;
                end
            end
        end
    endtask

    function automatic logic [D-1:0] exp_sel();
        logic [D-1:0] r;
        r = '0;
        if (m_t >= G && m_on[m_idx]) r[m_idx] = 1'b1;
        return r;
    endfunction

    task automatic check_all();
        chk("sel", 32'(digit_sel), 32'(exp_sel()));
        chk("nibble", 32'({x1, x2, x3, x4}), 32'(m_val[m_idx]));
        chk("tick", 32'(frame_tick), 32'(m_tick));
        chk("onehot0", 32'($onehot0(digit_sel)), 32'd1);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        cyc_n++;
        if (frame_tick === 1'b1) begin
            prev_tick = last_tick;
            last_tick = cyc_n;
        end
        check_all();
    endtask

    task automatic wr(input int addr, input int data, input bit on);
        wr_en = 1'b1;
        wr_addr = 3'(addr);
        wr_data = 4'(data);
        wr_on = on;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic wait_slot(input int di, input int tpos);
        int n;
        n = 0;
        while (!(m_idx == di && m_t == tpos) && n < 200) begin
            cyc();
            n++;
        end
        chk("wait_slot_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic check_period();
        int n;
        n = 0;
        last_tick = -1;
        prev_tick = -1;
        while (prev_tick < 0 && n < 3 * FRAME) begin
            cyc();
            n++;
        end
        chk("frame_period", 32'(last_tick - prev_tick), 32'(FRAME));
    endtask

    logic [3:0] idle_tab [12] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1,
                                  4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2};
    logic [3:0] disp_tab [4] = '{4'hA, 4'h3, 4'h7, 4'hF};

    initial begin
        logic [D-1:0] s;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_sel", 32'(digit_sel), 32'd0);

        // Release reset: cycle 0 is the first cycle after release
        rst = 1'b0;
        chk("idle_sel_c0", 32'(digit_sel), 32'(idle_tab[0]));
        check_all();
        for (int c = 1; c < 12; c++) begin
            cyc();
            chk("idle_sel", 32'(digit_sel), 32'(idle_tab[c]));
            chk("idle_nibble", 32'({x1, x2, x3, x4}), 32'd0);
        end

        // Write and display
        wr(0, 'hA, 1'b1);
        wr(1, 'h3, 1'b1);
        wr(2, 'h7, 1'b1);
        wr(3, 'hF, 1'b1);
        for (int d = 0; d < D; d++) begin
            wait_slot(d, G);
            s = '0;
            s[d] = 1'b1;
            chk("disp_sel", 32'(digit_sel), 32'(s));
            chk("disp_nibble", 32'({x1, x2, x3, x4}), 32'(disp_tab[d]));
        end
        check_period();

        // Blanking digit 2
        wr(2, 'h7, 1'b0);
        wait_slot(2, G);
        for (int k = 0; k < W; k++) begin
            chk("blank_sel", 32'(digit_sel), 32'd0);
            chk("blank_nibble", 32'({x1, x2, x3, x4}), 32'h7);
            cyc();
        end
        check_period();

        // Out-of-range write is ignored
        wr(5, 'h9, 1'b1);
        for (int d = 0; d < D; d++) begin
            wait_slot(d, G);
            chk("oor_nibble", 32'({x1, x2, x3, x4}), 32'(disp_tab[d]));
        end

        // Drop scan_en mid-SHOW of digit 1
        wait_slot(1, G + 1);
        scan_en = 1'b0;
        cyc();
        chk("hold_sel", 32'(digit_sel), 32'd0);
        repeat (3) begin
            cyc();
            chk("hold_tick", 32'(frame_tick), 32'd0);
            chk("hold_nibble", 32'({x1, x2, x3, x4}), 32'h3);
        end
        scan_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("resume_sel", 32'(digit_sel), (k >= 1 && k <= 4) ? 32'h2 : 32'h0);
        end

        // Drop scan_en on the last SHOW cycle of digit 3: no tick, index held
        wait_slot(3, G + W - 1);
        scan_en = 1'b0;
        cyc();
        chk("hold3_tick", 32'(frame_tick), 32'd0);
        chk("hold3_nibble", 32'({x1, x2, x3, x4}), 32'hF);
        scan_en = 1'b1;

        // Live update of the lit digit
        wait_slot(0, G);
        wr(0, 'h5, 1'b1);
        chk("live_nibble", 32'({x1, x2, x3, x4}), 32'h5);
        chk("live_sel", 32'(digit_sel), 32'h1);

        // Asynchronous reset between edges during SHOW of digit 3
        wait_slot(3, G + 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_sel", 32'(digit_sel), 32'd0);
        chk("arst_nibble", 32'({x1, x2, x3, x4}), 32'd0);
        check_all();
        #1;
        rst = 1'b0;
        for (int c = 1; c < 12; c++) begin
            cyc();
            chk("post_rst_sel", 32'(digit_sel), 32'(idle_tab[c]));
        end

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            wr_en = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 4'($urandom);
            wr_on = ($urandom_range(0, 4) != 0);
            scan_en = ($urandom_range(0, 29) != 0);
            cyc();
        end
        wr_en = 1'b0;
        scan_en = 1'b1;
        repeat (FRAME) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
